// File: rtl/pc_redirect_ctrl.sv
// Fetch PC redirect controller: boot sequencing, branch redirect with stall-time
// pending capture, single-level interrupt entry and return.
module pc_redirect_ctrl #(
   parameter int BOOT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc,
   input  logic        imem_ready,
   input  logic        hazard_stall,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   input  logic        irq,
   input  logic        eret,
   output logic [1:0]  pc_sel,
   output logic [31:0] pc_branch,
   output logic        stall,
   output logic        flush,
   output logic [31:0] epc,
   output logic        irq_ack,
   output logic        in_isr
);

   typedef enum logic [1:0] {BOOT, RUN, IRQ_WAIT, ISR} state_t;

   localparam int CW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          pend_br_q, pend_br_d;
   logic [31:0]   pend_tgt_q, pend_tgt_d;
   logic          pend_eret_q, pend_eret_d;
   logic [31:0]   epc_q, epc_d;
   logic          irq_ack_q, irq_ack_d;
   logic          in_isr_q, in_isr_d;
   logic          eret_req;
   logic          enter;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pend_br_d   = pend_br_q;
      pend_tgt_d  = pend_tgt_q;
      pend_eret_d = pend_eret_q;
      epc_d       = epc_q;
      irq_ack_d   = 1'b0;
      enter       = 1'b0;
      pc_sel      = 2'b10;
      pc_branch   = pend_br_q ? pend_tgt_q : 32'h0;
      stall       = 1'b0;
      flush       = 1'b0;
      eret_req    = (state_q == ISR) && (eret || pend_eret_q);

      if (state_q == BOOT) begin
         pc_sel = 2'b00;
         if (cnt_q == CW'(BOOT_CYCLES - 1)) state_d = RUN;
         else                               cnt_d   = cnt_q + 1'b1;
      end else begin
         stall = ~imem_ready | hazard_stall;
         // An eret that is not applied this cycle stays owed until it wins.
         if (state_q == ISR && eret) pend_eret_d = 1'b1;

         if (stall) begin
            if (branch_taken) begin
               pend_br_d  = 1'b1;
               pend_tgt_d = branch_target;
               pc_sel     = 2'b11;
               pc_branch  = branch_target;
            end else if (pend_br_q) begin
               pc_sel = 2'b11;
            end
         end else begin
            flush     = 1'b1;
            pend_br_d = 1'b0;
            if (branch_taken) begin
               pc_sel    = 2'b11;
               pc_branch = branch_target;
            end else if (pend_br_q) begin
               pc_sel = 2'b11;
            end else if (eret_req) begin
               pc_sel      = 2'b11;
               pc_branch   = epc_q;
               pend_eret_d = 1'b0;
               state_d     = RUN;
            end else if (state_q != ISR && irq) begin
               enter     = 1'b1;
               pc_sel    = 2'b01;
               epc_d     = pc;
               irq_ack_d = 1'b1;
               state_d   = ISR;
            end else begin
               flush = 1'b0;
            end
         end

         // RUN and IRQ_WAIT differ only in whether an interrupt is still owed.
         if (state_q != ISR && !enter) state_d = irq ? IRQ_WAIT : RUN;
      end

      in_isr_d = (state_d == ISR);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= BOOT;
         cnt_q       <= '0;
         pend_br_q   <= 1'b0;
         pend_tgt_q  <= 32'h0;
         pend_eret_q <= 1'b0;
         epc_q       <= 32'h0;
         irq_ack_q   <= 1'b0;
         in_isr_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pend_br_q   <= pend_br_d;
         pend_tgt_q  <= pend_tgt_d;
         pend_eret_q <= pend_eret_d;
         epc_q       <= epc_d;
         irq_ack_q   <= irq_ack_d;
         in_isr_q    <= in_isr_d;
      end
   end

   assign epc     = epc_q;
   assign irq_ack = irq_ack_q;
   assign in_isr  = in_isr_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Bench for pc_redirect_ctrl: directed scenarios with literal expectations plus
// a per-cycle comparison against an abstract model of the redirect rules.
module tb_pc_redirect_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] r_pc = 32'h0;
   logic        r_rdy = 1'b1, r_hz = 1'b0, r_br = 1'b0, r_irq = 1'b0, r_eret = 1'b0;
   logic [31:0] r_tgt = 32'h0;
   logic [1:0]  pc_sel;
   logic [31:0] pc_branch, epc;
   logic        stall, flush, irq_ack, in_isr;

   int checks = 0;
   int errs   = 0;

   pc_redirect_ctrl #(.BOOT_CYCLES(2)) dut (
      .clk(clk), .reset(rst), .pc(r_pc), .imem_ready(r_rdy),
      .hazard_stall(r_hz), .branch_taken(r_br), .branch_target(r_tgt),
      .irq(r_irq), .eret(r_eret), .pc_sel(pc_sel), .pc_branch(pc_branch),
      .stall(stall), .flush(flush), .epc(epc), .irq_ack(irq_ack), .in_isr(in_isr)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Abstract model: boot countdown, isr flag, a youngest-wins pending target,
   // and an owed-eret flag. No notion of a waiting state is needed.
   int          m_boot;
   bit          m_isr, m_ack, m_pend, m_owed;
   logic [31:0] m_epc, m_tgt;

   always @(negedge clk) begin
      logic [1:0]  e_sel;
      logic [31:0] e_br;
      bit          e_stall, e_flush, ack_n;
      if (rst) begin
         m_boot = 2; m_isr = 0; m_ack = 0; m_pend = 0; m_owed = 0;
         m_epc = 0; m_tgt = 0;
         check("rst_sel", {30'h0, pc_sel}, 32'h0);
         check("rst_stall", {31'h0, stall}, 32'h0);
         check("rst_flush", {31'h0, flush}, 32'h0);
         check("rst_isr", {31'h0, in_isr}, 32'h0);
         check("rst_ack", {31'h0, irq_ack}, 32'h0);
         check("rst_epc", epc, 32'h0);
      end else begin
         check("m_isr", {31'h0, in_isr}, {31'h0, m_isr});
         check("m_ack", {31'h0, irq_ack}, {31'h0, m_ack});
         check("m_epc", epc, m_epc);
         ack_n = 0;
         e_flush = 0;
         e_br = m_pend ? m_tgt : 32'h0;
         if (m_boot > 0) begin
            e_sel = 2'b00; e_stall = 0; m_boot--;
         end else begin
            e_sel = 2'b10;
            e_stall = !r_rdy || r_hz;
            if (e_stall) begin
               if (m_isr && r_eret) m_owed = 1;
               if (r_br) begin
                  e_sel = 2'b11; e_br = r_tgt; m_pend = 1; m_tgt = r_tgt;
               end else if (m_pend) e_sel = 2'b11;
            end else if (r_br || m_pend) begin
               e_sel = 2'b11; e_flush = 1;
               if (r_br) e_br = r_tgt;
               m_pend = 0;
               if (m_isr && r_eret) m_owed = 1;
            end else if (m_isr && (r_eret || m_owed)) begin
               e_sel = 2'b11; e_br = m_epc; e_flush = 1; m_isr = 0; m_owed = 0;
            end else if (!m_isr && r_irq) begin
               e_sel = 2'b01; e_flush = 1; m_epc = r_pc; ack_n = 1; m_isr = 1;
            end
         end
         m_ack = ack_n;
         check("m_sel", {30'h0, pc_sel}, {30'h0, e_sel});
         check("m_br", pc_branch, e_br);
         check("m_stall", {31'h0, stall}, {31'h0, e_stall});
         check("m_flush", {31'h0, flush}, {31'h0, e_flush});
      end
   end

   task automatic cyc(input logic rdy, input logic hz, input logic br, input logic [31:0] tgt,
                      input logic iq, input logic er, input logic [31:0] p);
      @(posedge clk);
      #1;
      r_rdy = rdy; r_hz = hz; r_br = br; r_tgt = tgt; r_irq = iq; r_eret = er; r_pc = p;
      @(negedge clk);
      #1;
   endtask

   task automatic idle(input logic [31:0] p);
      cyc(1, 0, 0, 0, 0, 0, p);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk); #1;
      check("boot0_sel", {30'h0, pc_sel}, 32'h0);
      idle(0);
      check("boot1_sel", {30'h0, pc_sel}, 32'h0);
      idle(1);
      check("run_sel", {30'h0, pc_sel}, 32'h2);
      check("run_stall", {31'h0, stall}, 32'h0);

      // Branch during memory stall is held, then applied when the stall lifts.
      cyc(0, 0, 1, 32'h40, 0, 0, 2);
      check("bst0_sel", {30'h0, pc_sel}, 32'h3);
      check("bst0_br", pc_branch, 32'h40);
      check("bst0_stall", {31'h0, stall}, 32'h1);
      cyc(0, 0, 0, 0, 0, 0, 2);
      check("bst1_br", pc_branch, 32'h40);
      cyc(0, 0, 0, 0, 0, 0, 2);
      check("bst2_sel", {30'h0, pc_sel}, 32'h3);
      check("bst2_flush", {31'h0, flush}, 32'h0);
      idle(2);
      check("bst3_flush", {31'h0, flush}, 32'h1);
      check("bst3_br", pc_branch, 32'h40);
      idle(32'h40);
      check("bst4_sel", {30'h0, pc_sel}, 32'h2);
      check("bst4_br", pc_branch, 32'h0);

      // Interrupt entry at pc 0x20.
      cyc(1, 0, 0, 0, 1, 0, 32'h20);
      check("irq_sel", {30'h0, pc_sel}, 32'h1);
      check("irq_flush", {31'h0, flush}, 32'h1);
      idle(32'h100);
      check("irq_ack1", {31'h0, irq_ack}, 32'h1);
      check("irq_epc", epc, 32'h20);
      check("irq_isr", {31'h0, in_isr}, 32'h1);
      idle(32'h101);
      check("irq_ack2", {31'h0, irq_ack}, 32'h0);

      // Return with irq held, then immediate re-entry.
      cyc(1, 0, 0, 0, 1, 1, 32'h102);
      check("eret_sel", {30'h0, pc_sel}, 32'h3);
      check("eret_br", pc_branch, 32'h20);
      cyc(1, 0, 0, 0, 1, 0, 32'h20);
      check("reent_isr0", {31'h0, in_isr}, 32'h0);
      check("reent_sel", {30'h0, pc_sel}, 32'h1);
      idle(32'h100);
      check("reent_ack", {31'h0, irq_ack}, 32'h1);

      // Stalled eret is owed until the stall clears.
      cyc(1, 1, 0, 0, 0, 1, 32'h101);
      check("eretst_sel", {30'h0, pc_sel}, 32'h2);
      check("eretst_flush", {31'h0, flush}, 32'h0);
      idle(32'h101);
      check("eretp_sel", {30'h0, pc_sel}, 32'h3);
      check("eretp_br", pc_branch, 32'h20);
      idle(32'h20);
      check("eretp_isr", {31'h0, in_isr}, 32'h0);

      // Branch beats a simultaneous interrupt; entry follows next cycle.
      cyc(1, 0, 1, 32'h80, 1, 0, 32'h21);
      check("bi_sel", {30'h0, pc_sel}, 32'h3);
      check("bi_br", pc_branch, 32'h80);
      cyc(1, 0, 0, 0, 1, 0, 32'h80);
      check("bi_sel2", {30'h0, pc_sel}, 32'h1);
      idle(32'h200);
      check("bi_epc", epc, 32'h80);

      // Youngest pending branch wins.
      cyc(1, 1, 1, 32'h100, 0, 0, 32'h201);
      cyc(1, 1, 1, 32'h200, 0, 0, 32'h201);
      check("yw_br", pc_branch, 32'h200);
      idle(32'h201);
      check("yw_apply", pc_branch, 32'h200);

      // eret losing to a branch is applied in the following cycle.
      cyc(1, 0, 1, 32'h300, 0, 1, 32'h200);
      check("el_br", pc_branch, 32'h300);
      idle(32'h300);
      check("el_ret", pc_branch, 32'h80);
      idle(32'h80);

      // Deferred irq that drops before eligibility is never taken.
      cyc(1, 1, 0, 0, 1, 0, 32'h81);
      check("drop_sel", {30'h0, pc_sel}, 32'h2);
      idle(32'h81);
      check("drop_flush", {31'h0, flush}, 32'h0);
      cyc(1, 0, 0, 0, 0, 1, 32'h82);
      check("eret_out_flush", {31'h0, flush}, 32'h0);

      // Asynchronous reset mid-ISR with a branch pending.
      cyc(1, 0, 0, 0, 1, 0, 32'h55);
      idle(32'h60);
      cyc(1, 1, 1, 32'h99, 0, 0, 32'h61);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("arst_sel", {30'h0, pc_sel}, 32'h0);
      check("arst_isr", {31'h0, in_isr}, 32'h0);
      check("arst_epc", epc, 32'h0);
      r_hz = 1'b0; r_br = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk); #1;
      check("reboot0", {30'h0, pc_sel}, 32'h0);
      idle(0);
      check("reboot1", {30'h0, pc_sel}, 32'h0);
      idle(1);
      check("reboot_run", {30'h0, pc_sel}, 32'h2);
      check("reboot_br", pc_branch, 32'h0);

      for (int i = 0; i < 400; i++)
         cyc(($urandom % 4) != 0, ($urandom % 5) == 0, ($urandom % 6) == 0, $urandom,
             ($urandom % 3) == 0, ($urandom % 5) == 0, $urandom);

      idle(0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
      $finish;
   end

endmodule

// File: doc/pc_redirect_ctrl.md
PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

Interface
REQ-001 The block SHALL have parameter BOOT_CYCLES, default 2, giving the number of cycles pc_sel holds 2'b00 after reset release.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port pc, input, 32 bits: the current fetch PC, word-addressed.
REQ-005 The block SHALL have port imem_ready, input, 1 bit: instruction memory ready; low forces a stall.
REQ-006 The block SHALL have port hazard_stall, input, 1 bit: stall request from decode.
REQ-007 The block SHALL have port branch_taken, input, 1 bit: one-cycle pulse from execute.
REQ-008 The block SHALL have port branch_target, input, 32 bits: target accompanying branch_taken.
REQ-009 The block SHALL have port irq, input, 1 bit: level-sensitive interrupt request.
REQ-010 The block SHALL have port eret, input, 1 bit: one-cycle return-from-interrupt pulse.
REQ-011 The block SHALL have port pc_sel, output, 2 bits: 00 reset vector, 01 interrupt vector, 10 pc+1, 11 pc_branch.
REQ-012 The block SHALL have port pc_branch, output, 32 bits: redirect target.
REQ-013 The block SHALL have port stall, output, 1 bit: freezes the fetch PC register.
REQ-014 The block SHALL have port flush, output, 1 bit: high in any cycle a redirect is applied.
REQ-015 The block SHALL have port epc, output, 32 bits: saved resume PC.
REQ-016 The block SHALL have port irq_ack, output, 1 bit: one-cycle acknowledge pulse.
REQ-017 The block SHALL have port in_isr, output, 1 bit: high while in an interrupt service routine.

Function
REQ-018 The FSM SHALL have states BOOT, RUN, IRQ_WAIT and ISR; in_isr SHALL be high only in ISR.
REQ-019 In BOOT: pc_sel=00, stall=0, flush=0; an internal counter SHALL increment each cycle, and the FSM SHALL go to RUN when the count reaches BOOT_CYCLES-1.
REQ-020 Outside BOOT: stall SHALL be the combinational value (~imem_ready | hazard_stall).
REQ-021 A redirect SHALL be applied only in a cycle with stall=0, and flush SHALL equal (a redirect is applied).
REQ-022 If branch_taken arrives while stall=1, the block SHALL latch branch_target into a pending register; pending SHALL be set, and pc_sel=11 with pc_branch=pending target SHALL be driven until the first stall=0 cycle, in which pending clears.
REQ-023 A new branch_taken while pending is set SHALL overwrite the pending target (youngest wins).
REQ-024 Redirect priority in a non-stalled cycle SHALL be: live branch_taken > pending branch > eret (ISR only) > interrupt entry > sequential (pc_sel=10).
REQ-025 When irq=1 in RUN: if no branch is live or pending and stall=0, the block SHALL drive pc_sel=01 and capture epc<=pc, pulse irq_ack=1 in the next cycle, and go to ISR; otherwise it SHALL go to IRQ_WAIT.
REQ-026 IRQ_WAIT SHALL behave as RUN and SHALL perform interrupt entry at the first cycle eligible per REQ-025; if irq drops before then, it SHALL return to RUN without entry.
REQ-027 In ISR, irq SHALL be ignored (no nesting); branches SHALL be handled per REQ-022..024.
REQ-028 eret in ISR with stall=0 and no live or pending branch SHALL drive pc_sel=11 and pc_branch=epc, and go to RUN; an eret that loses to a branch or arrives while stalled SHALL be held pending until it is applied.
REQ-029 eret outside ISR SHALL be ignored.
REQ-030 When no redirect is applied, pc_branch SHALL equal the pending target if set, else 0.

Reset
REQ-031 Asserting reset SHALL immediately force state=BOOT, counter=0, pending flags=0, epc=0, irq_ack=0, in_isr=0, pc_sel=00, stall=0, flush=0, independent of clk.
REQ-032 Reset asserted mid-ISR or mid-pending SHALL discard all saved state; BOOT SHALL restart with the full BOOT_CYCLES count.

Verification
REQ-033 Release reset, imem_ready=1 -> pc_sel=00 for exactly 2 cycles, then pc_sel=10 and stall=0.
REQ-034 In RUN, pulse branch_taken with target 0x40 while imem_ready=0 for 3 cycles -> stall=1 for 3 cycles with pc_sel=11 and pc_branch=0x40 held; flush=1 on the 4th cycle; pc_sel=10 on the 5th.
REQ-035 pc=0x20, irq=1, no stall -> pc_sel=01 and flush=1 that cycle; irq_ack=1 for the next cycle only; epc=0x20; in_isr=1.
REQ-036 In ISR with epc=0x20, pulse eret -> pc_sel=11, pc_branch=0x20, in_isr=0 next cycle; irq held high then re-enters the ISR.
REQ-037 Assert branch_taken (target 0x80) and irq in the same unstalled RUN cycle -> pc_sel=11 to 0x80; interrupt entry (pc_sel=01) occurs the following cycle.
REQ-038 Assert reset asynchronously mid-ISR -> pc_sel=00 and in_isr=0 before the next clk edge; epc=0.
